// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//             direction counters. It predicts at fetch and detects
//             mispredictions when a branch or jump resolves in EX. It also
//             keeps saturating branch and mispredict counters.
//  Ports    :
//    clk                    rising-edge clock
//    reset                  asynchronous active-low reset
//    pcF                    fetch PC to look up
//    hitF/predtakenF/       combinational lookup result for pcF
//      predtargetF
//    updE, pcE, takenE,     resolution of a branch/jump in EX
//      targetE, isjumpE
//    predtakenE/predtargetE prediction carried down with the instruction
//    inval                  synchronous invalidate-all
//    mispredictE/recoverE   redirect request and correct next PC
//    brcnt/misscnt          resolved-branch / mispredict counters
//  Revision : 1.0  initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PCW     = 32,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PCW-1:0]  pcF,
    output logic            hitF,
    output logic            predtakenF,
    output logic [PCW-1:0]  predtargetF,
    input  logic            updE,
    input  logic [PCW-1:0]  pcE,
    input  logic            takenE,
    input  logic [PCW-1:0]  targetE,
    input  logic            isjumpE,
    input  logic            predtakenE,
    input  logic [PCW-1:0]  predtargetE,
    input  logic            inval,
    output logic            mispredictE,
    output logic [PCW-1:0]  recoverE,
    output logic [CNTW-1:0] brcnt,
    output logic [CNTW-1:0] misscnt
);

    localparam int              c_iw       = $clog2(ENTRIES);
    localparam int              c_tw       = PCW - c_iw - 2;
    localparam logic [PCW-1:0]  c_pc_step  = PCW'(4);
    localparam logic [CNTW-1:0] c_cnt_one  = CNTW'(1);
    localparam logic [1:0]      c_ctr_max  = 2'b11;
    localparam logic [1:0]      c_ctr_min  = 2'b00;
    localparam logic [1:0]      c_ctr_wt   = 2'b10;
    localparam logic [1:0]      c_ctr_rst  = 2'b01;

    // Entry storage
    logic [ENTRIES-1:0] r_valid;
    logic [c_tw-1:0]    r_tag    [ENTRIES];
    logic [PCW-1:0]     r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [CNTW-1:0]    r_brcnt;
    logic [CNTW-1:0]    r_misscnt;

    // Fetch-side lookup
    logic [c_iw-1:0]    w_idxF;
    logic [c_tw-1:0]    w_tagF;
    logic               w_hitF;

    // Execute-side index/tag and hit against pre-update state
    logic [c_iw-1:0]    w_idxE;
    logic [c_tw-1:0]    w_tagE;
    logic               w_hitE;
    logic               w_mispredict;
    logic [1:0]         w_ctrE;

    // Instruction-aligned PCs: the byte offset bits never address the table
    logic               w_unused_pcf_lsb;
    assign w_unused_pcf_lsb = &{1'b0, pcF[1:0]};

    assign w_idxF = pcF[c_iw+1:2];
    assign w_tagF = pcF[PCW-1:c_iw+2];
    assign w_hitF = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);

    assign hitF        = w_hitF;
    assign predtakenF  = w_hitF & r_ctr[w_idxF][1];
    assign predtargetF = w_hitF ? r_target[w_idxF] : '0;

    assign w_idxE = pcE[c_iw+1:2];
    assign w_tagE = pcE[PCW-1:c_iw+2];
    assign w_hitE = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);
    assign w_ctrE = r_ctr[w_idxE];

    // A taken branch that was predicted taken can still be wrong if the
    // stored target went stale (e.g. an aliasing entry or a changed jr).
    assign w_mispredict = updE & ((predtakenE != takenE) |
                                  (takenE & predtakenE & (predtargetE != targetE)));

    assign mispredictE = w_mispredict;
    assign recoverE    = takenE ? targetE : (pcE + c_pc_step);

    assign brcnt   = r_brcnt;
    assign misscnt = r_misscnt;

    // Table update. Invalidate wins over a same-cycle update and touches
    // only the valid bits, so counters/tags/targets survive it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_ctr_rst;
            end
        end else if (inval) begin
            r_valid <= '0;
        end else if (updE) begin
            if (w_hitE) begin
                if (isjumpE) begin
                    r_ctr[w_idxE]    <= c_ctr_max;
                    r_target[w_idxE] <= targetE;
                end else if (takenE) begin
                    if (w_ctrE != c_ctr_max) begin
                        r_ctr[w_idxE] <= w_ctrE + 2'b01;
                    end
                    r_target[w_idxE] <= targetE;
                end else if (w_ctrE != c_ctr_min) begin
                    r_ctr[w_idxE] <= w_ctrE - 2'b01;
                end
            end else if (takenE) begin
                // Allocate, evicting whatever aliased into this slot
                r_valid[w_idxE]  <= 1'b1;
                r_tag[w_idxE]    <= w_tagE;
                r_target[w_idxE] <= targetE;
                r_ctr[w_idxE]    <= isjumpE ? c_ctr_max : c_ctr_wt;
            end
        end
    end

    // Saturating performance counters; only reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_brcnt   <= '0;
            r_misscnt <= '0;
        end else begin
            if (updE && (r_brcnt != '1)) begin
                r_brcnt <= r_brcnt + c_cnt_one;
            end
            if (w_mispredict && (r_misscnt != '1)) begin
                r_misscnt <= r_misscnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage pipelined MIPS core. The core currently predicts not-taken and always flushes on a taken branch, jump or jr. This block predicts at fetch and tells the pipeline when to redirect. Lookup is combinational against the fetch PC. Updates and misprediction detection happen when the branch or jump resolves in EX. The block also keeps saturating performance counters.

## Interface
- ENTRIES, 16, number of direct-mapped entries; power of two, ≥2; IW = log2(ENTRIES)
- PCW, 32, PC and target width
- CNTW, 16, width of the performance counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- pcF  in  PCW  fetch-stage PC to look up
- hitF  out  1  valid entry whose tag matches pcF
- predtakenF  out  1  hitF & counter[1]
- predtargetF  out  PCW  stored target of the matching entry; 0 when hitF=0
- updE  in  1  a non-flushed branch/jump resolves in EX this cycle
- pcE  in  PCW  PC of the resolving instruction
- takenE  in  1  actual direction
- targetE  in  PCW  actual taken target
- isjumpE  in  1  unconditional (j/jal)
- predtakenE, predtargetE  in  1/PCW  prediction carried down the pipe with the instruction
- inval  in  1  synchronous invalidate-all
- mispredictE  out  1  redirect required this cycle
- recoverE  out  PCW  correct next PC
- brcnt, misscnt  out  CNTW  resolved-branch count / mispredict count

## Operation
- Index = pc[IW+1:2]; tag = pc[PCW-1:IW+2]. Each entry holds valid, tag, target and a 2-bit counter ctr.
- Lookup: hit = valid[idx(pcF)] & tag match. Outputs are purely combinational from the current state.
- Update, at the clock edge when updE=1 and inval=0:
  - Hit, conditional branch: taken → ctr saturating-increments (max 11); not taken → ctr saturating-decrements (min 00). The target is written only when taken.
  - Hit, isjumpE: ctr=11; the target is written.
  - Miss, takenE=1: allocate or overwrite the entry. valid=1, new tag, target=targetE, ctr = isjumpE ? 11 : 10.
  - Miss, takenE=0: no state change.
- mispredictE = updE & ((predtakenE≠takenE) | (takenE & predtakenE & predtargetE≠targetE)).
- recoverE = takenE ? targetE : pcE+4. The add is modulo 2^PCW.
- inval=1: all valid bits clear at the next edge. It has priority: a simultaneous update is dropped. ctr, tag and target are left unchanged.
- Counters:
  - brcnt increments on every updE.
  - misscnt increments on every mispredictE.
  - Both saturate at all-ones, are unaffected by inval, and clear only on reset.
- Reset (asynchronous, reset=0): all valid=0, ctr=01, tag=0, target=0, brcnt=0, misscnt=0.
  - Resulting outputs: hitF=0, predtakenF=0, predtargetF=0.
  - mispredictE=0 while updE=0.

## Timing
- Lookup latency 0 cycles. An update becomes visible to a lookup on the cycle after the edge.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update state (read-before-write).
- mispredictE and recoverE are combinational in the updE cycle. The pipeline flushes IF/ID and loads recoverE into the PC at the next edge.
- Counter outputs are registered and reflect events up to the previous edge.
- Reset asserted mid-operation clears state immediately, independent of clk. Deassertion takes effect at the next edge.

## Test plan
- **Reset:** hold reset=0, then release; pcF=0x00400010 → hitF=0, predtakenF=0, predtargetF=0, brcnt=misscnt=0.
- **Allocate:** updE, pcE=0x00400010, takenE=1, targetE=0x00400000, predtakenE=0 → mispredictE=1, recoverE=0x00400000.
  - Next cycle, pcF=0x00400010 → hitF=1, predtakenF=1, predtargetF=0x00400000, brcnt=1, misscnt=1.
- **Hysteresis:** on that entry apply NT, NT, NT, then T, T.
  - ctr goes 10→01→00→00→01→10; predtakenF after each update = 0,0,0,0,1.
  - First NT with predtakenE=1 → mispredictE=1, recoverE=0x00400014.
- **Alias and jump:** updE, pcE=0x00400050 (same index 4, different tag), isjumpE=1, takenE=1, targetE=0x00400100 → entry replaced.
  - pcF=0x00400010 → hitF=0.
  - pcF=0x00400050 → predtakenF=1, predtargetF=0x00400100.
- **Invalidate with update, and wrap:** inval=1 with a same-cycle allocating updE → next cycle every index misses; brcnt still increments.
  - updE, pcE=0xFFFFFFFC, takenE=0, predtakenE=1 → recoverE=0x00000000.
- **Saturation and async reset:** CNTW=4, issue 20 mispredicting updates → brcnt=misscnt=15.
  - Drop reset mid-cycle → counters and hitF clear before the next clk edge.
